// File: rtl/down_counter_4bit_load.sv
// down_counter_4bit_load
// Loadable synchronous down counter with a one-cycle terminal-count pulse.
// A load arms the counter (RUN) with a non-zero value. Each enabled clock in
// RUN decrements it. Reaching the terminal count either stops the counter at
// zero (one-shot) or reloads the last loaded value (periodic timer).
module down_counter_4bit_load #(
    parameter int WIDTH       = 4,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] rl_reg;
    logic [WIDTH-1:0] rl_next;
    logic             done_reg;
    logic             done_next;
    logic             terminal;

    // Terminal count: the enabled edge that would take q from 1 to 0.
    assign terminal = (q_reg == WIDTH'(1));

    // State, count, reload value and done pulse; clear is immediate.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            rl_reg    <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            rl_reg    <= rl_next;
            done_reg  <= done_next;
        end
    end

    // Next-state logic: load beats counting, counting only happens in RUN.
    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        rl_next    = rl_reg;
        done_next  = 1'b0;

        if (load) begin
            // A load discards whatever the counter would have done this edge.
            q_next     = d;
            rl_next    = d;
            state_next = (d != '0) ? RUN : IDLE;
        end else if ((state_reg == RUN) && en) begin
            if (terminal) begin
                done_next = 1'b1;
                if (AUTO_RELOAD != 0) begin
                    // Periodic mode: q jumps straight back, never showing 0.
                    q_next = rl_reg;
                end else begin
                    q_next     = '0;
                    state_next = IDLE;
                end
            end else if (q_reg != '0) begin
                // Guard keeps 0 from ever wrapping to all-ones.
                q_next = q_reg - WIDTH'(1);
            end
        end
    end

    assign q    = q_reg;
    assign zero = (q_reg == '0);
    assign busy = (state_reg == RUN);
    assign done = done_reg;

endmodule
